vga_sync_ctrl: RTL and testbench

VGA_SYNC_CTRL -- requirements
Module: vga_sync_ctrl

---
 rtl/vga_timing_pkg.sv | 56 +++++
 rtl/vga_sync_ctrl_if.sv | 35 +++
 rtl/vga_axis_cnt.sv | 49 ++++
 rtl/vga_sync_ctrl.sv | 140 ++++++++++++++
 tb/tb_vga_sync_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared timing constants for the VGA sync controller. Holds the default
// 800x600@60 (40 MHz pixel clock) timing, the totals and active-region
// bounds derived from it, the coordinate type, the pipeline stage record
// that carries sync/active flags towards the pins, and small helpers used
// to derive region bounds from per-instance parameters.
package vga_timing_pkg;

    // Default horizontal timing, in pixel clocks
    localparam int H_SYNC = 128;
    localparam int H_BP   = 88;
    localparam int H_ACT  = 800;
    localparam int H_FP   = 40;

    // Default vertical timing, in lines
    localparam int V_SYNC = 4;
    localparam int V_BP   = 23;
    localparam int V_ACT  = 600;
    localparam int V_FP   = 1;

    // Derived totals and active-region bounds (active = [LO, HI))
    localparam int H_TOT    = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOT    = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int H_ACT_LO = H_SYNC + H_BP;
    localparam int H_ACT_HI = H_SYNC + H_BP + H_ACT;
    localparam int V_ACT_LO = V_SYNC + V_BP;
    localparam int V_ACT_HI = V_SYNC + V_BP + V_ACT;

    // All counter and coordinate arithmetic is 11-bit unsigned
    typedef logic [10:0] coord_t;

    // Coordinate value reported outside the active area
    localparam coord_t COORD_NONE = 11'd2047;

    // Flags travelling down the delay pipeline alongside the pixel
    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } stage_t;

    // A stage holding the blanked, sync-inactive state
    function automatic stage_t idle_stage(input logic pol);
        stage_t s;
        s.hs  = ~pol;
        s.vs  = ~pol;
        s.act = 1'b0;
        return s;
    endfunction

    // First active count of an axis: sync plus back porch
    function automatic coord_t act_lo(input int sync_len, input int bp_len);
        return coord_t'(sync_len + bp_len);
    endfunction

endpackage

// File: rtl/vga_sync_ctrl_if.sv
// vga_sync_ctrl_if
// Display-layer handshake between the timing controller and the layer that
// supplies overlay pixels. The controller (master) publishes the active-area
// coordinate and a frame pulse; the display layer (slave) answers one clock
// later with its pixel-on flag and colour.
//   current_x, current_y : coordinate of the pixel being fetched (2047 = none)
//   frame_start          : one-clock pulse at the start of each frame
//   enable               : overlay pixel-on returned by the display layer
//   buf_rgb              : overlay colour {R,G,B} returned by the display layer
interface vga_sync_ctrl_if;
    import vga_timing_pkg::*;

    coord_t      current_x;
    coord_t      current_y;
    logic        frame_start;
    logic        enable;
    logic [23:0] buf_rgb;

    modport master (
        output current_x,
        output current_y,
        output frame_start,
        input  enable,
        input  buf_rgb
    );

    modport slave (
        input  current_x,
        input  current_y,
        input  frame_start,
        output enable,
        output buf_rgb
    );

endinterface

// File: rtl/vga_axis_cnt.sv
// vga_axis_cnt
// One timing axis (horizontal or vertical). Counts 0..TOT-1 on each clock
// where inc is high and wraps to 0 after the terminal count. Regions are
// laid out as sync, back porch, active, front porch.
//   clk   : pixel clock
//   rst_n : synchronous active-low reset, clears the count
//   inc   : advance the count this clock
//   cnt   : current count
//   sync  : count lies in the sync region
//   act   : count lies in the active region
//   term  : count is at TOT-1 (wraps on the next advance)
module vga_axis_cnt
    import vga_timing_pkg::*;
#(
    parameter int p_SYNC = H_SYNC,
    parameter int p_BP   = H_BP,
    parameter int p_ACT  = H_ACT,
    parameter int p_FP   = H_FP
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   inc,
    output coord_t cnt,
    output logic   sync,
    output logic   act,
    output logic   term
);

    localparam int     TOT     = p_SYNC + p_BP + p_ACT + p_FP;
    localparam coord_t LAST    = coord_t'(TOT - 1);
    localparam coord_t SYNC_HI = coord_t'(p_SYNC);
    localparam coord_t ACT_LO  = act_lo(p_SYNC, p_BP);
    localparam coord_t ACT_HI  = coord_t'(p_SYNC + p_BP + p_ACT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= term ? '0 : cnt + 11'd1;
        end
    end

    always_comb begin
        term = (cnt == LAST);
        sync = (cnt < SYNC_HI);
        act  = (cnt >= ACT_LO) && (cnt < ACT_HI);
    end

endmodule

// File: rtl/vga_sync_ctrl.sv
// vga_sync_ctrl
// VGA timing generator with a three-stage pixel pipeline.
//   stage 0 : h/v counters
//   stage 1 : CURRENT_X/CURRENT_Y and FRAME_START presented to the display layer
//   stage 2 : display layer answers with ENABLE/VGA_BUF_RGB
//   stage 3 : all pins (sync, blank, colour) registered on the same edge
// Ports:
//   VGA_CLK, RST_N          : pixel clock, synchronous active-low reset
//   ENABLE, VGA_BUF_RGB     : overlay pixel-on and colour from the display layer
//   CURRENT_X, CURRENT_Y    : active-area coordinate (2047 outside active area)
//   FRAME_START             : one-clock pulse for counter position (0,0)
//   VGA_HS, VGA_VS          : sync pins, active level p_SYNC_POL
//   VGA_BLANK_N             : high during active video
//   VGA_R, VGA_G, VGA_B     : colour pins, zero while blanked
module vga_sync_ctrl
    import vga_timing_pkg::*;
#(
    parameter int          p_H_SYNC   = H_SYNC,
    parameter int          p_H_BP     = H_BP,
    parameter int          p_H_ACT    = H_ACT,
    parameter int          p_H_FP     = H_FP,
    parameter int          p_V_SYNC   = V_SYNC,
    parameter int          p_V_BP     = V_BP,
    parameter int          p_V_ACT    = V_ACT,
    parameter int          p_V_FP     = V_FP,
    parameter logic        p_SYNC_POL = 1'b1,
    parameter logic [23:0] p_BG_RGB   = 24'h00_00_00
) (
    input  logic        VGA_CLK,
    input  logic        RST_N,
    input  logic        ENABLE,
    input  logic [23:0] VGA_BUF_RGB,
    output coord_t      CURRENT_X,
    output coord_t      CURRENT_Y,
    output logic        FRAME_START,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B
);

    localparam coord_t H_LO = act_lo(p_H_SYNC, p_H_BP);
    localparam coord_t V_LO = act_lo(p_V_SYNC, p_V_BP);

    coord_t h_cnt;
    coord_t v_cnt;
    logic   h_sync;
    logic   v_sync;
    logic   h_act;
    logic   v_act;
    logic   h_term;
    logic   v_term;
    logic   at_origin;
    stage_t s1;
    stage_t s2;

    vga_axis_cnt #(
        .p_SYNC (p_H_SYNC),
        .p_BP   (p_H_BP),
        .p_ACT  (p_H_ACT),
        .p_FP   (p_H_FP)
    ) u_h_cnt (
        .clk   (VGA_CLK),
        .rst_n (RST_N),
        .inc   (1'b1),
        .cnt   (h_cnt),
        .sync  (h_sync),
        .act   (h_act),
        .term  (h_term)
    );

    // The vertical axis only advances when a line wraps
    vga_axis_cnt #(
        .p_SYNC (p_V_SYNC),
        .p_BP   (p_V_BP),
        .p_ACT  (p_V_ACT),
        .p_FP   (p_V_FP)
    ) u_v_cnt (
        .clk   (VGA_CLK),
        .rst_n (RST_N),
        .inc   (h_term),
        .cnt   (v_cnt),
        .sync  (v_sync),
        .act   (v_act),
        .term  (v_term)
    );

    // (0,0) is reached only from reset or from the joint terminal count, so a
    // flag tracking those two events marks the origin without a 22-bit compare.
    always_ff @(posedge VGA_CLK) begin
        if (!RST_N) begin
            at_origin <= 1'b1;
        end else begin
            at_origin <= h_term && v_term;
        end
    end

    // Stages 1..3. Sync flags travel with the pixel so every pin toggles on
    // the same edge, three clocks after the counter position they describe.
    always_ff @(posedge VGA_CLK) begin
        if (!RST_N) begin
            CURRENT_X   <= COORD_NONE;
            CURRENT_Y   <= COORD_NONE;
            FRAME_START <= 1'b0;
            s1          <= idle_stage(p_SYNC_POL);
            s2          <= idle_stage(p_SYNC_POL);
            VGA_HS      <= ~p_SYNC_POL;
            VGA_VS      <= ~p_SYNC_POL;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= 8'h00;
            VGA_G       <= 8'h00;
            VGA_B       <= 8'h00;
        end else begin
            if (h_act && v_act) begin
                CURRENT_X <= h_cnt - H_LO;
                CURRENT_Y <= v_cnt - V_LO;
            end else begin
                CURRENT_X <= COORD_NONE;
                CURRENT_Y <= COORD_NONE;
            end
            FRAME_START <= at_origin;
            s1.hs       <= h_sync ? p_SYNC_POL : ~p_SYNC_POL;
            s1.vs       <= v_sync ? p_SYNC_POL : ~p_SYNC_POL;
            s1.act      <= h_act && v_act;
            s2          <= s1;
            VGA_HS      <= s2.hs;
            VGA_VS      <= s2.vs;
            VGA_BLANK_N <= s2.act;
            // The overlay answer is only trusted inside the active area
            if (s2.act) begin
                {VGA_R, VGA_G, VGA_B} <= ENABLE ? VGA_BUF_RGB : p_BG_RGB;
            end else begin
                {VGA_R, VGA_G, VGA_B} <= 24'h00_00_00;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// tb_vga_sync_ctrl
// Self-checking bench for vga_sync_ctrl using a reduced timing so whole
// frames fit in a short run. Expected pin values are pushed to a queue when
// the counter position that produces them is reached and popped when the
// pins for that position appear three clocks later.
module tb_vga_sync_ctrl;
    import vga_timing_pkg::*;

    localparam int          T_HS   = 8;
    localparam int          T_HBP  = 6;
    localparam int          T_HA   = 20;
    localparam int          T_HFP  = 4;
    localparam int          T_VS   = 2;
    localparam int          T_VBP  = 3;
    localparam int          T_VA   = 10;
    localparam int          T_VFP  = 2;
    localparam int          HT     = T_HS + T_HBP + T_HA + T_HFP;
    localparam int          VT     = T_VS + T_VBP + T_VA + T_VFP;
    localparam int          FRAME  = HT * VT;
    localparam logic        POL    = 1'b1;
    localparam logic [23:0] BG     = 24'h0A0B0C;
    localparam int          TX     = 12;
    localparam int          TY     = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hs_pin;
    logic vs_pin;
    logic blank_n;
    logic [7:0] r_pin;
    logic [7:0] g_pin;
    logic [7:0] b_pin;

    vga_sync_ctrl_if bus ();

    always #5 clk = ~clk;

    vga_sync_ctrl #(
        .p_H_SYNC   (T_HS),
        .p_H_BP     (T_HBP),
        .p_H_ACT    (T_HA),
        .p_H_FP     (T_HFP),
        .p_V_SYNC   (T_VS),
        .p_V_BP     (T_VBP),
        .p_V_ACT    (T_VA),
        .p_V_FP     (T_VFP),
        .p_SYNC_POL (POL),
        .p_BG_RGB   (BG)
    ) dut (
        .VGA_CLK     (clk),
        .RST_N       (rst_n),
        .ENABLE      (bus.enable),
        .VGA_BUF_RGB (bus.buf_rgb),
        .CURRENT_X   (bus.current_x),
        .CURRENT_Y   (bus.current_y),
        .FRAME_START (bus.frame_start),
        .VGA_HS      (hs_pin),
        .VGA_VS      (vs_pin),
        .VGA_BLANK_N (blank_n),
        .VGA_R       (r_pin),
        .VGA_G       (g_pin),
        .VGA_B       (b_pin)
    );

    int checks = 0;
    int passed = 0;
    int fails = 0;
    int k = 0;
    int mode = 0;
    logic [26:0] exp_q[$];
    coord_t prev_x = COORD_NONE;
    coord_t prev_y = COORD_NONE;
    int vs_count = 0;
    int hs_count = 0;
    int blank_count = 0;
    int white_count = 0;

    localparam logic [26:0] PINS_IDLE = {~POL, ~POL, 1'b0, 24'h000000};

    // Expected {HS, VS, BLANK_N, RGB} for counter position p in the frame
    function automatic logic [26:0] exp_pins(input int p);
        int h;
        int v;
        logic hs;
        logic vs;
        logic act;
        logic [23:0] rgb;
        h   = p % HT;
        v   = (p / HT) % VT;
        hs  = (h < T_HS) ? POL : ~POL;
        vs  = (v < T_VS) ? POL : ~POL;
        act = (h >= T_HS + T_HBP) && (h < T_HS + T_HBP + T_HA) &&
              (v >= T_VS + T_VBP) && (v < T_VS + T_VBP + T_VA);
        if (!act)
            rgb = 24'h000000;
        else if (mode == 1)
            rgb = 24'h123456;
        else if ((h - T_HS - T_HBP == TX) && (v - T_VS - T_VBP == TY))
            rgb = 24'hFFFFFF;
        else
            rgb = BG;
        return {hs, vs, act, rgb};
    endfunction

    // Expected {CURRENT_X, CURRENT_Y} for counter position p
    function automatic logic [21:0] exp_xy(input int p);
        int h;
        int v;
        h = p % HT;
        v = (p / HT) % VT;
        if ((h >= T_HS + T_HBP) && (h < T_HS + T_HBP + T_HA) &&
            (v >= T_VS + T_VBP) && (v < T_VS + T_VBP + T_VA))
            return {11'(h - T_HS - T_HBP), 11'(v - T_VS - T_VBP)};
        return {COORD_NONE, COORD_NONE};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h (k=%0d)", tag, obs, expv, k);
        end
    endtask

    // Display-layer model: answers one clock after the coordinate it saw
    task automatic apply_stimulus();
        logic hit;
        if (!rst_n || mode == 2) begin
            bus.enable  = 1'b0;
            bus.buf_rgb = 24'h000000;
        end else if (mode == 1) begin
            bus.enable  = 1'b1;
            bus.buf_rgb = 24'h123456;
        end else begin
            hit = (prev_x == 11'(TX)) && (prev_y == 11'(TY));
            bus.enable  = hit;
            bus.buf_rgb = hit ? 24'hFFFFFF : 24'hA5A5A5;
        end
        prev_x = bus.current_x;
        prev_y = bus.current_y;
    endtask

    task automatic run_cycles(input int n);
        logic [26:0] obs;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            k++;
            exp_q.push_back(exp_pins(k));
            @(negedge clk);
            check_output("xy", {10'd0, bus.current_x, bus.current_y}, {10'd0, exp_xy(k - 1)});
            check_output("frame_start", {31'd0, bus.frame_start},
                         {31'd0, ((k - 1) % FRAME) == 0});
            obs = {hs_pin, vs_pin, blank_n, r_pin, g_pin, b_pin};
            if (exp_q.size() == 0) begin
                check_output("pins_queue_empty", {5'd0, obs}, 32'hFFFFFFFF);
            end else begin
                check_output("pins", {5'd0, obs}, {5'd0, exp_q.pop_front()});
            end
            if (k >= 3 && k < 3 + FRAME) begin
                if (vs_pin == POL) vs_count++;
                if (hs_pin == POL) hs_count++;
                if (blank_n) blank_count++;
                if ({r_pin, g_pin, b_pin} == 24'hFFFFFF) white_count++;
            end
            apply_stimulus();
        end
    endtask

    // One reset clock, check every output, then release at (0,0)
    task automatic do_reset();
        rst_n = 1'b0;
        bus.enable  = 1'b1;
        bus.buf_rgb = 24'hFFFFFF;
        @(posedge clk);
        @(negedge clk);
        check_output("rst_xy", {10'd0, bus.current_x, bus.current_y},
                     {10'd0, COORD_NONE, COORD_NONE});
        check_output("rst_frame_start", {31'd0, bus.frame_start}, 32'd0);
        check_output("rst_pins", {5'd0, hs_pin, vs_pin, blank_n, r_pin, g_pin, b_pin},
                     {5'd0, PINS_IDLE});
        rst_n = 1'b1;
        k = 0;
        exp_q.delete();
        exp_q.push_back(PINS_IDLE);
        exp_q.push_back(PINS_IDLE);
        exp_q.push_back(exp_pins(0));
        prev_x = COORD_NONE;
        prev_y = COORD_NONE;
        vs_count = 0;
        hs_count = 0;
        blank_count = 0;
        white_count = 0;
        apply_stimulus();
    endtask

    initial begin
        bus.enable  = 1'b0;
        bus.buf_rgb = 24'h000000;

        // Overlay single pixel over one full frame plus margin
        $display("[TB] phase 1: single overlay pixel");
        mode = 0;
        do_reset();
        run_cycles(FRAME + 10);
        check_output("vs_clocks_per_frame", vs_count, T_VS * HT);
        check_output("hs_clocks_per_frame", hs_count, T_HS * VT);
        check_output("blank_clocks_per_frame", blank_count, T_HA * T_VA);
        check_output("white_pixels", white_count, 1);

        // Overlay always on with a constant colour: must be masked when blanked
        $display("[TB] phase 2: blank masking");
        mode = 1;
        do_reset();
        run_cycles(FRAME + 5);
        check_output("mask_blank_clocks", blank_count, T_HA * T_VA);

        // Reset mid-frame, then confirm a clean restart from the origin
        $display("[TB] phase 3: mid-frame reset");
        mode = 0;
        do_reset();
        run_cycles(6 * HT + 5);
        do_reset();
        run_cycles(2 * HT + 10);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
